// File: rtl/camera_capture_rgb444_if.sv
// DrawPoint write port: one registered point (X, Y, RGB12) per Update strobe.
interface camera_capture_rgb444_if;
  logic        poul1Update;
  logic [8:0]  poul9PosX;
  logic [8:0]  poul9PosY;
  logic [11:0] poul12Rgb12Data;

  modport master (output poul1Update, poul9PosX, poul9PosY, poul12Rgb12Data);
  modport slave  (input  poul1Update, poul9PosX, poul9PosY, poul12Rgb12Data);
endinterface

// File: rtl/camera_capture_rgb444.sv
// Camera RGB444 byte-stream capture with 2^DECIM_LOG2 decimation per axis,
// emitting frame-buffer write points in the camera pixel-clock domain.
module camera_capture_rgb444 #(
  parameter int SRC_H_RES  = 640,
  parameter int SRC_V_RES  = 480,
  parameter int DECIM_LOG2 = 1
) (
  input  logic                           piul1Clock,
  input  logic                           piul1Reset_n,
  input  logic                           piul1Enable,
  input  logic                           piul1CamVSync,
  input  logic                           piul1CamHRef,
  input  logic [7:0]                     piul8CamData,
  camera_capture_rgb444_if.master        point_if,
  output logic                           poul1FrameDone,
  output logic                           poul1Busy,
  output logic                           poul1LineError
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARM      = 2'd1;
  localparam logic [1:0] ST_WAIT_END = 2'd2;
  localparam logic [1:0] ST_CAPTURE  = 2'd3;

  localparam logic [9:0] H_LIM    = 10'(SRC_H_RES);
  localparam logic [9:0] V_LIM    = 10'(SRC_V_RES);
  localparam logic [9:0] DEC_MASK = 10'((1 << DECIM_LOG2) - 1);

  logic [1:0]  state_q, state_d;
  logic        phase_q, phase_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  line_q, line_d;
  logic [3:0]  red_q, red_d;
  logic        href_q, vsync_q;
  logic        upd_q, upd_d;
  logic [8:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [11:0] rgb_q, rgb_d;
  logic        fd_q, fd_d;
  logic        err_q, err_d;

  logic [9:0]  col_inc, line_inc;
  logic        keep;

  always_comb begin
    // Counters hold at all-ones so an overlong frame never aliases onto row/column 0.
    col_inc  = (col_q == '1) ? col_q : col_q + 10'd1;
    line_inc = (line_q == '1) ? line_q : line_q + 10'd1;
    keep     = ((col_q & DEC_MASK) == '0) && ((line_q & DEC_MASK) == '0) &&
               (col_q < H_LIM) && (line_q < V_LIM);

    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    line_d  = line_q;
    red_d   = red_q;
    upd_d   = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    rgb_d   = rgb_q;
    fd_d    = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        phase_d = 1'b0;
        if (piul1Enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        phase_d = 1'b0;
        if (piul1CamVSync) state_d = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        phase_d = 1'b0;
        if (vsync_q && !piul1CamVSync) begin
          state_d = ST_CAPTURE;
          col_d   = '0;
          line_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (piul1CamVSync) begin
          // Frame end wins over any line activity; a half-received pair is dropped.
          fd_d    = 1'b1;
          phase_d = 1'b0;
          state_d = piul1Enable ? ST_WAIT_END : ST_IDLE;
        end else if (piul1CamHRef) begin
          if (!href_q && (line_q >= V_LIM)) err_d = 1'b1;
          if (!phase_q) begin
            red_d   = piul8CamData[3:0];
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            col_d   = col_inc;
            if (keep) begin
              upd_d = 1'b1;
              x_d   = 9'(col_q >> DECIM_LOG2);
              y_d   = 9'(line_q >> DECIM_LOG2);
              rgb_d = {red_q, piul8CamData};
            end
          end
        end else begin
          phase_d = 1'b0;
          if (href_q) begin
            line_d = line_inc;
            col_d  = '0;
            if (phase_q || (col_q != H_LIM)) err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      col_q   <= '0;
      line_q  <= '0;
      red_q   <= '0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      upd_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      line_q  <= line_d;
      red_q   <= red_d;
      href_q  <= piul1CamHRef;
      vsync_q <= piul1CamVSync;
      upd_q   <= upd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rgb_q   <= rgb_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign point_if.poul1Update     = upd_q;
  assign point_if.poul9PosX       = x_q;
  assign point_if.poul9PosY       = y_q;
  assign point_if.poul12Rgb12Data = rgb_q;
  assign poul1FrameDone           = fd_q;
  assign poul1Busy                = (state_q != ST_IDLE);
  assign poul1LineError           = err_q;

endmodule

// File: tb/tb_camera_capture_rgb444.sv
// Bench for camera_capture_rgb444: a decimating (DECIM_LOG2=1) and a full-rate
// (DECIM_LOG2=0) instance share one scaled-down 32x24 camera stream.
module tb_camera_capture_rgb444;
  localparam int H = 32;
  localparam int V = 24;

  logic       clk = 1'b0;
  logic       rst_n, en, vs, hr;
  logic [7:0] d;
  logic       fd_a, busy_a, err_a, fd_b, busy_b, err_b;

  always #5 clk = ~clk;

  camera_capture_rgb444_if pa ();
  camera_capture_rgb444_if pb ();

  camera_capture_rgb444 #(.SRC_H_RES(H), .SRC_V_RES(V), .DECIM_LOG2(1)) dut_a (
    .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en), .piul1CamVSync(vs),
    .piul1CamHRef(hr), .piul8CamData(d), .point_if(pa),
    .poul1FrameDone(fd_a), .poul1Busy(busy_a), .poul1LineError(err_a));

  camera_capture_rgb444 #(.SRC_H_RES(H), .SRC_V_RES(V), .DECIM_LOG2(0)) dut_b (
    .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en), .piul1CamVSync(vs),
    .piul1CamHRef(hr), .piul8CamData(d), .point_if(pb),
    .poul1FrameDone(fd_b), .poul1Busy(busy_b), .poul1LineError(err_b));

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [11:0] rgb;
  } point_t;

  typedef struct {
    int nlines;
    int odd_line;
    bit err;
    int na;
    int nb;
  } frame_vec_t;

  int         checks = 0;
  int         errors = 0;
  point_t     qa[$];
  point_t     qb[$];
  int         upd_cnt[2];
  int         fd_cnt[2];
  int         exp_fd = 0;
  int         cyc = 0;
  int         last_cyc[2];
  logic [8:0] last_x[2];
  logic [8:0] last_y[2];
  bit         have_last[2];
  logic [11:0] rgb53 = '0;
  bit         cap_on = 0;
  bit         exp_err = 0;
  int         line_idx = 0;
  logic [7:0] lbuf [0:127];
  frame_vec_t tab [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] outs_a();
    return {pa.poul1Update, pa.poul9PosX, pa.poul9PosY, pa.poul12Rgb12Data, fd_a, busy_a, err_a};
  endfunction

  function automatic logic [33:0] outs_b();
    return {pb.poul1Update, pb.poul9PosX, pb.poul9PosY, pb.poul12Rgb12Data, fd_b, busy_b, err_b};
  endfunction

  task automatic mon_point(input int k, input logic [8:0] x, input logic [8:0] y, input logic [11:0] rgb);
    point_t e;
    bit     empty;
    upd_cnt[k]++;
    empty = (k == 0) ? (qa.size() == 0) : (qb.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL unexpected_update dut%0d: got x=%0d y=%0d rgb=%0h required no update", k, x, y, rgb);
    end else begin
      e = (k == 0) ? qa.pop_front() : qb.pop_front();
      check($sformatf("point_dut%0d", k), {x, y, rgb}, e);
    end
    if (have_last[k] && y == last_y[k] && int'(x) == int'(last_x[k]) + 1)
      check($sformatf("spacing_dut%0d", k), cyc - last_cyc[k], (k == 0) ? 4 : 2);
    have_last[k] = 1;
    last_x[k]    = x;
    last_y[k]    = y;
    last_cyc[k]  = cyc;
    if (k == 0 && x == 9'd5 && y == 9'd3) rgb53 = rgb;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (pa.poul1Update) mon_point(0, pa.poul9PosX, pa.poul9PosY, pa.poul12Rgb12Data);
    if (pb.poul1Update) mon_point(1, pb.poul9PosX, pb.poul9PosY, pb.poul12Rgb12Data);
    if (fd_a) fd_cnt[0]++;
    if (fd_b) fd_cnt[1]++;
  end

  // Expected points come straight from pixel/line indices and the decimation rule.
  task automatic expect_points(input int nb);
    point_t p;
    for (int c = 0; c < nb / 2; c++) begin
      for (int k = 0; k < 2; k++) begin
        int dl;
        int m;
        dl = (k == 0) ? 1 : 0;
        m  = (1 << dl) - 1;
        if ((c & m) == 0 && (line_idx & m) == 0 && c < H && line_idx < V) begin
          p.x   = 9'(c >> dl);
          p.y   = 9'(line_idx >> dl);
          p.rgb = {lbuf[2*c][3:0], lbuf[2*c+1]};
          if (k == 0) qa.push_back(p);
          else        qb.push_back(p);
        end
      end
    end
  endtask

  // evt: 0 none, 1 raise enable at byte evt_at, 2 reset for 3 cycles at byte evt_at
  task automatic send_line(input int nb, input bit pat, input int evt_at, input int evt);
    bit post;
    post = 0;
    for (int b = 0; b < nb; b++)
      lbuf[b] = pat ? ((b % 2 == 0) ? 8'((b / 2) & 15) : {4'(line_idx), 4'hA}) : 8'($urandom);
    if (cap_on) begin
      if (line_idx >= V) exp_err = 1;
      else expect_points(nb);
    end
    hr = 1;
    for (int b = 0; b < nb; b++) begin
      d = lbuf[b];
      if (b == evt_at && evt == 1) begin
        check("busy_before_enable", busy_a, 1'b0);
        en   = 1;
        post = 1;
      end
      if (b == evt_at && evt == 2) begin
        rst_n = 0;
        #1;
        check("outs_a_in_reset", outs_a(), '0);
        check("outs_b_in_reset", outs_b(), '0);
        repeat (3) tick();
        check("outs_a_end_reset", outs_a(), '0);
        check("outs_b_end_reset", outs_b(), '0);
        rst_n = 1;
        qa.delete();
        qb.delete();
        cap_on    = 0;
        exp_err   = 0;
        have_last = '{0, 0};
        post      = 1;
      end
      tick();
      if (post) begin
        post = 0;
        check("busy_a_after_event", busy_a, 1'b1);
        check("busy_b_after_event", busy_b, 1'b1);
      end
    end
    hr = 0;
    d  = '0;
    if (cap_on && ((nb % 2) != 0 || nb / 2 != H)) exp_err = 1;
    line_idx++;
    repeat (4) tick();
    if (cap_on) begin
      check("line_err_a", err_a, exp_err);
      check("line_err_b", err_b, exp_err);
    end
  endtask

  task automatic vs_pulse(input bit end_cap, input bit start_cap);
    hr = 0;
    vs = 1;
    repeat (3) tick();
    if (end_cap) exp_fd++;
    check("framedone_cnt_a", fd_cnt[0], exp_fd);
    check("framedone_cnt_b", fd_cnt[1], exp_fd);
    check("leftover_a", qa.size(), 0);
    check("leftover_b", qb.size(), 0);
    vs = 0;
    repeat (3) tick();
    cap_on    = start_cap;
    line_idx  = 0;
    have_last = '{0, 0};
    if (start_cap) begin
      exp_err = 0;
      upd_cnt = '{0, 0};
      check("err_a_frame_start", err_a, 1'b0);
      check("err_b_frame_start", err_b, 1'b0);
    end
  endtask

  task automatic frame_counts(input int na, input int nb);
    check("upd_count_a", upd_cnt[0], na);
    check("upd_count_b", upd_cnt[1], nb);
  endtask

  initial begin
    tab[0] = '{24, -1, 0, 192, 768};
    tab[1] = '{24, 10, 1, 192, 767};
    tab[2] = '{26, -1, 1, 192, 768};
    tab[3] = '{20, -1, 0, 160, 640};
    tab[4] = '{24,  7, 1, 192, 767};
    upd_cnt   = '{0, 0};
    fd_cnt    = '{0, 0};
    have_last = '{0, 0};
    rst_n = 1; en = 0; vs = 0; hr = 0; d = '0;
    #2 rst_n = 0;
    #1;
    check("reset_outs_a", outs_a(), '0);
    check("reset_outs_b", outs_b(), '0);
    repeat (3) tick();
    rst_n = 1;
    tick();
    check("idle_busy_a", busy_a, 1'b0);

    // Patterned frame: R = column, G = line, B = 0xA
    en = 1;
    tick();
    check("busy_a_enable", busy_a, 1'b1);
    check("busy_b_enable", busy_b, 1'b1);
    vs_pulse(0, 1);
    for (int l = 0; l < V; l++) send_line(2 * H, 1, -1, 0);
    frame_counts(192, 768);
    check("rgb_at_5_3", rgb53, 12'hA6A);

    for (int i = 0; i < 5; i++) begin
      vs_pulse(1, 1);
      for (int l = 0; l < tab[i].nlines; l++)
        send_line((l == tab[i].odd_line) ? 2 * H - 1 : 2 * H, 0, -1, 0);
      frame_counts(tab[i].na, tab[i].nb);
      check("tab_err_a", err_a, tab[i].err);
      check("tab_err_b", err_b, tab[i].err);
    end

    // Enable dropped mid-frame: frame still completes, then idle
    vs_pulse(1, 1);
    for (int l = 0; l < V; l++) begin
      if (l == 3) en = 0;
      send_line(2 * H, 0, -1, 0);
    end
    frame_counts(192, 768);
    vs_pulse(1, 0);
    check("busy_a_after_disable", busy_a, 1'b0);

    // Enable raised mid-line: nothing until a full VSYNC boundary
    for (int l = 0; l < V; l++) send_line(2 * H, 0, (l == 5) ? 7 : -1, (l == 5) ? 1 : 0);
    vs_pulse(0, 1);
    for (int l = 0; l < V; l++) send_line(2 * H, 0, -1, 0);
    frame_counts(192, 768);

    // Reset mid-line 12, released with enable still high
    vs_pulse(1, 1);
    for (int l = 0; l < V; l++) send_line(2 * H, 0, (l == 12) ? 20 : -1, (l == 12) ? 2 : 0);
    vs_pulse(0, 1);
    for (int l = 0; l < V; l++) send_line(2 * H, 0, -1, 0);
    frame_counts(192, 768);
    en = 0;
    vs_pulse(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
